// File: rtl/imdct_band_scheduler.sv
// ---------------------------------------------------------------------------
// imdct_band_scheduler
//
// Per-channel subband sequencer for the IMDCT stage. On a granule start every
// channel walks SUBBANDS subbands: it pulses start_subband, presents the base
// address and effective block type, then waits for band_done from its
// compute/window/overlap chain. When every channel has finished, all channels
// return to IDLE together and stage_done pulses once.
//
// Optional feature (macro IMDCT_SCHED_WATCHDOG_EN):
//   per-channel watchdog on the WAIT state; on expiry the channel sets a
//   sticky timeout_err bit and advances as if band_done had arrived.
//   Without the macro no counter is built and timeout_err is constant 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   stage_ready           start-of-granule pulse (honoured only when idle)
//   block_type            side info, channel c in bits [2c+1:2c]
//   window_switching_flag side info, one bit per channel
//   mixed_block_flag      side info, one bit per channel
//   band_done             per-channel "current subband written back" pulse
//   start_subband         per-channel single-cycle launch pulse
//   base_address          per-channel first line of the current subband
//   block_type_out        per-channel effective block type
//   busy                  any channel not IDLE
//   stage_done            single-cycle granule completion pulse
//   timeout_err           sticky per-channel watchdog flag
// ---------------------------------------------------------------------------
module imdct_band_scheduler #(
    parameter int NUM_CH         = 2,
    parameter int SUBBANDS       = 32,
    parameter int LINES_PER_BAND = 18,
    parameter int ADDR_W         = 10,
    parameter int MIXED_BANDS    = 2,
    parameter int TIMEOUT        = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stage_ready,
    input  logic [2*NUM_CH-1:0]   block_type,
    input  logic [NUM_CH-1:0]     window_switching_flag,
    input  logic [NUM_CH-1:0]     mixed_block_flag,
    input  logic [NUM_CH-1:0]     band_done,
    output logic [NUM_CH-1:0]     start_subband,
    output logic [ADDR_W*NUM_CH-1:0] base_address,
    output logic [2*NUM_CH-1:0]   block_type_out,
    output logic                  busy,
    output logic                  stage_done,
    output logic [NUM_CH-1:0]     timeout_err
);

    localparam int BAND_W = (SUBBANDS > 1) ? $clog2(SUBBANDS) : 1;
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(SUBBANDS - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(LINES_PER_BAND);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    state_e            state_q  [NUM_CH];
    state_e            state_d  [NUM_CH];
    logic [BAND_W-1:0] band_q   [NUM_CH];
    logic [BAND_W-1:0] band_d   [NUM_CH];
    logic [ADDR_W-1:0] base_q   [NUM_CH];
    logic [ADDR_W-1:0] base_d   [NUM_CH];
    logic [1:0]        bt_lat_q [NUM_CH];
    logic [1:0]        bt_lat_d [NUM_CH];
    logic [NUM_CH-1:0] mix_lat_q, mix_lat_d;
    logic [NUM_CH-1:0] wsf_lat_q, wsf_lat_d;

    logic [NUM_CH-1:0]   start_q, start_d;
    logic [2*NUM_CH-1:0] bt_out_q, bt_out_d;
    logic                busy_q, busy_d;
    logic                stage_done_q, stage_done_d;

    logic                all_idle;
    logic                all_fin;
    logic                launch;
    logic [NUM_CH-1:0]   adv;

`ifdef IMDCT_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // The counter starts at 0 on the first WAIT cycle, so it expires on the
    // TIMEOUT-th WAIT cycle when it holds TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0]   wd_q [NUM_CH];
    logic [WD_W-1:0]   wd_d [NUM_CH];
    logic [NUM_CH-1:0] to_q, to_d;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        all_idle = 1'b1;
        all_fin  = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_q[c] != S_IDLE) all_idle = 1'b0;
            if (state_q[c] != S_FIN)  all_fin  = 1'b0;
        end
        launch = stage_ready && all_idle;

        busy_d       = 1'b0;
        // Channels only leave FIN together, so all_fin is true for one cycle.
        stage_done_d = all_fin;
        start_d      = '0;
        bt_out_d     = '0;
        mix_lat_d    = mix_lat_q;
        wsf_lat_d    = wsf_lat_q;
        adv          = '0;
`ifdef IMDCT_SCHED_WATCHDOG_EN
        to_d         = to_q;
`endif

        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            band_d[c]   = band_q[c];
            base_d[c]   = base_q[c];
            bt_lat_d[c] = bt_lat_q[c];
            adv[c]      = band_done[c];
`ifdef IMDCT_SCHED_WATCHDOG_EN
            wd_d[c]     = wd_q[c];
`endif

            unique case (state_q[c])
                S_IDLE: begin
                    if (launch) begin
                        bt_lat_d[c]  = block_type[2*c +: 2];
                        mix_lat_d[c] = mixed_block_flag[c];
                        wsf_lat_d[c] = window_switching_flag[c];
                        band_d[c]    = '0;
                        base_d[c]    = '0;
                        state_d[c]   = S_START;
                    end
                end
                S_START: begin
                    // band_done is not looked at here: a completion in the
                    // launch cycle cannot belong to the band just launched.
                    state_d[c] = S_WAIT;
`ifdef IMDCT_SCHED_WATCHDOG_EN
                    wd_d[c] = '0;
`endif
                end
                S_WAIT: begin
`ifdef IMDCT_SCHED_WATCHDOG_EN
                    wd_d[c] = wd_q[c] + WD_W'(1);
                    if (!band_done[c] && wd_q[c] == WD_LAST) begin
                        adv[c]  = 1'b1;
                        to_d[c] = 1'b1;
                    end
`endif
                    if (adv[c]) begin
                        if (band_q[c] == LAST_BAND) begin
                            state_d[c] = S_FIN;
                        end else begin
                            // Incremental stride keeps a multiplier off the path.
                            band_d[c]  = band_q[c] + BAND_W'(1);
                            base_d[c]  = base_q[c] + STRIDE;
                            state_d[c] = S_START;
                        end
                    end
                end
                S_FIN: begin
                    if (all_fin) state_d[c] = S_IDLE;
                end
                default: state_d[c] = S_IDLE;
            endcase

            // Outputs are registered from next-state values so they line up
            // with the state they describe.
            start_d[c] = (state_d[c] == S_START);
            busy_d     = busy_d | (state_d[c] != S_IDLE);
            bt_out_d[2*c +: 2] =
                (mix_lat_d[c] && wsf_lat_d[c] && int'(band_d[c]) < MIXED_BANDS)
                ? 2'b00 : bt_lat_d[c];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= S_IDLE;
                band_q[c]   <= '0;
                base_q[c]   <= '0;
                bt_lat_q[c] <= '0;
`ifdef IMDCT_SCHED_WATCHDOG_EN
                wd_q[c]     <= '0;
`endif
            end
            mix_lat_q    <= '0;
            wsf_lat_q    <= '0;
            start_q      <= '0;
            bt_out_q     <= '0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
`ifdef IMDCT_SCHED_WATCHDOG_EN
            to_q         <= '0;
`endif
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                band_q[c]   <= band_d[c];
                base_q[c]   <= base_d[c];
                bt_lat_q[c] <= bt_lat_d[c];
`ifdef IMDCT_SCHED_WATCHDOG_EN
                wd_q[c]     <= wd_d[c];
`endif
            end
            mix_lat_q    <= mix_lat_d;
            wsf_lat_q    <= wsf_lat_d;
            start_q      <= start_d;
            bt_out_q     <= bt_out_d;
            busy_q       <= busy_d;
            stage_done_q <= stage_done_d;
`ifdef IMDCT_SCHED_WATCHDOG_EN
            to_q         <= to_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_base
        assign base_address[g*ADDR_W +: ADDR_W] = base_q[g];
    end

    assign start_subband  = start_q;
    assign block_type_out = bt_out_q;
    assign busy           = busy_q;
    assign stage_done     = stage_done_q;

`ifdef IMDCT_SCHED_WATCHDOG_EN
    assign timeout_err = to_q;
`else
    assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_imdct_band_scheduler.sv
// ---------------------------------------------------------------------------
// tb_imdct_band_scheduler
//
// Bench for imdct_band_scheduler (2 channels, 32 subbands, stride 18).
// Per-channel responders return band_done a chosen number of cycles after
// each observed start_subband. Each observed start is compared with the
// expected base (band * stride) and effective block type of that band, and
// the stage_done/busy timing is compared with the cycle of the last
// band_done. Side-info inputs are scrambled after every launch.
// ---------------------------------------------------------------------------
module tb_imdct_band_scheduler;

    localparam int NUM_CH   = 2;
    localparam int SUBBANDS = 32;
    localparam int LPB      = 18;
    localparam int ADDR_W   = 10;
    localparam int TIMEOUT  = 15;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     stage_ready = 1'b0;
    logic [2*NUM_CH-1:0]      block_type = '0;
    logic [NUM_CH-1:0]        window_switching_flag = '0;
    logic [NUM_CH-1:0]        mixed_block_flag = '0;
    logic [NUM_CH-1:0]        band_done = '0;
    logic [NUM_CH-1:0]        start_subband;
    logic [ADDR_W*NUM_CH-1:0] base_address;
    logic [2*NUM_CH-1:0]      block_type_out;
    logic                     busy;
    logic                     stage_done;
    logic [NUM_CH-1:0]        timeout_err;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    imdct_band_scheduler #(
        .NUM_CH(NUM_CH), .SUBBANDS(SUBBANDS), .LINES_PER_BAND(LPB),
        .ADDR_W(ADDR_W), .MIXED_BANDS(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .stage_ready(stage_ready),
        .block_type(block_type),
        .window_switching_flag(window_switching_flag),
        .mixed_block_flag(mixed_block_flag),
        .band_done(band_done),
        .start_subband(start_subband),
        .base_address(base_address),
        .block_type_out(block_type_out),
        .busy(busy), .stage_done(stage_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic [1:0] exp_bt(input logic [1:0] bt, input logic m,
                                          input logic w, input int band);
        return (m && w && band < 2) ? 2'b00 : bt;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        stage_ready = 1'b0;
        band_done = '0;
        repeat (3) @(negedge clk);
        check("rst_start",  32'(start_subband),  0);
        check("rst_base",   32'(base_address),   0);
        check("rst_bt",     32'(block_type_out), 0);
        check("rst_busy",   32'(busy),           0);
        check("rst_done",   32'(stage_done),     0);
        check("rst_timeout", 32'(timeout_err),   0);
        rst = 1'b0;
    endtask

    // dly0/dly1: cycles from start to band_done (0 = random 1..5 per band).
    // ready_at: loop index for a mid-granule stage_ready (-1 = none).
    // reset_band: reset once ch0 has started this band (-1 = none).
    // drop_band: ch1 never answers this band (-1 = none).
    // noisy: inject band_done pulses that must be ignored.
    task automatic run_granule(input logic [3:0] bt_in, input logic [1:0] mix_in,
                               input logic [1:0] wsf_in, input int dly0, input int dly1,
                               input int ready_at, input int reset_band,
                               input int drop_band, input bit noisy);
        int  cd [NUM_CH];
        int  starts [NUM_CH];
        int  done_cyc [NUM_CH];
        bit  fin [NUM_CH];
        int  s_drop, last, n_sd, k, d;
        bit  all_done, completed;
        for (int c = 0; c < NUM_CH; c++) begin
            cd[c] = -1; starts[c] = 0; done_cyc[c] = 0; fin[c] = 1'b0;
        end
        s_drop = -1; last = 0; n_sd = 0; all_done = 1'b0; completed = 1'b0;

        @(negedge clk);
        check("idle_start", 32'(start_subband), 0);
        check("idle_busy",  32'(busy),          0);
        block_type = bt_in;
        mixed_block_flag = mix_in;
        window_switching_flag = wsf_in;
        stage_ready = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            stage_ready = (n == ready_at);
            block_type = 4'($urandom);
            mixed_block_flag = 2'($urandom);
            window_switching_flag = 2'($urandom);
            band_done = '0;

            // Responders.
            for (int c = 0; c < NUM_CH; c++) begin
                if (cd[c] > 0) begin
                    cd[c]--;
                    if (cd[c] == 0) begin
                        cd[c] = -1;
                        if (!(c == 1 && starts[1] - 1 == drop_band)) begin
                            band_done[c] = 1'b1;
                            if (starts[c] == SUBBANDS) begin
                                fin[c] = 1'b1;
                                done_cyc[c] = cyc;
                            end
                        end
                    end
                end
            end
            all_done = fin[0] && fin[1];
            last = (done_cyc[0] > done_cyc[1]) ? done_cyc[0] : done_cyc[1];

            if (n == 0) check("launch_start", 32'(start_subband), 3);
            check("busy", 32'(busy), (all_done && cyc >= last + 2) ? 0 : 1);
            if (stage_done) begin
                n_sd++;
                check("stage_done_cycle", cyc, all_done ? last + 2 : -1);
            end

            for (int c = 0; c < NUM_CH; c++) begin
                if (start_subband[c]) begin
                    k = starts[c];
                    if (cd[c] != -1 || k >= SUBBANDS) begin
                        check($sformatf("extra_start_ch%0d", c), 1, 0);
                    end else begin
                        check($sformatf("base_ch%0d_b%0d", c, k),
                              32'(base_address[c*ADDR_W +: ADDR_W]), k * LPB);
                        check($sformatf("bt_ch%0d_b%0d", c, k),
                              32'(block_type_out[2*c +: 2]),
                              32'(exp_bt(bt_in[2*c +: 2], mix_in[c], wsf_in[c], k)));
                        if (drop_band >= 0 && c == 1 && k == drop_band + 1) begin
                            check("wd_gap", cyc - s_drop, TIMEOUT + 1);
                            check("wd_flag", 32'(timeout_err), 2);
                        end
                        if (drop_band >= 0 && c == 1 && k == drop_band) s_drop = cyc;
                        starts[c]++;
                        d = (c == 0) ? dly0 : dly1;
                        cd[c] = (d == 0) ? int'($urandom_range(5, 1)) : d;
                        // Completion in the launch cycle must be ignored.
                        if (noisy && $urandom_range(3, 0) == 0) band_done[c] = 1'b1;
                    end
                end
                // Completions while in FIN (or back in IDLE) must be ignored.
                if (noisy && fin[c] && $urandom_range(1, 0) == 1) band_done[c] = 1'b1;
            end

            if (reset_band >= 0 && starts[0] == reset_band + 1) begin
                reset_dut();
                return;
            end
            if (all_done && cyc >= last + 5) begin
                completed = 1'b1;
                break;
            end
        end

        band_done = '0;
        stage_ready = 1'b0;
        if (!completed) begin
            check("granule_timeout", 0, 1);
        end else begin
            check("starts_ch0", starts[0], SUBBANDS);
            check("starts_ch1", starts[1], SUBBANDS);
            check("stage_done_count", n_sd, 1);
            check("timeout_err_end", 32'(timeout_err), (drop_band >= 0) ? 2 : 0);
        end
    endtask

    initial begin
        reset_dut();
        // Long blocks, band_done 4 cycles after each start.
        run_granule(4'h0, 2'b00, 2'b00, 4, 4, -1, -1, -1, 1'b0);
        // Long blocks, band_done 3 cycles after each start.
        run_granule(4'h0, 2'b00, 2'b00, 3, 3, -1, -1, -1, 1'b0);
        // Mixed short on ch0, pure short on ch1, minimum subband period.
        run_granule({2'd2, 2'd2}, 2'b01, 2'b11, 1, 1, -1, -1, -1, 1'b0);
        // Channel skew with an ignored mid-granule stage_ready.
        run_granule({2'd1, 2'd3}, 2'b11, 2'b01, 3, 13, 40, -1, -1, 1'b0);
        // Reset at band 7, then a clean restart.
        run_granule({2'd2, 2'd1}, 2'b11, 2'b11, 2, 2, -1, 7, -1, 1'b0);
        run_granule({2'd3, 2'd2}, 2'b10, 2'b11, 2, 2, -1, -1, -1, 1'b0);
        // Randomised side info and delays with ignored band_done noise.
        for (int i = 0; i < 4; i++) begin
            run_granule(4'($urandom), 2'($urandom), 2'($urandom), 0, 0,
                        int'($urandom_range(150, 10)), -1, -1, 1'b1);
        end
`ifdef IMDCT_SCHED_WATCHDOG_EN
        // ch1 never answers band 5; the watchdog must advance it.
        run_granule({2'd2, 2'd0}, 2'b00, 2'b00, 2, 2, -1, -1, 5, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imdct_band_scheduler.md
# imdct_band_scheduler

Parametrised per-channel subband sequencer for the IMDCT stage. It replaces the fixed two-channel controller and done-join logic with a generic design: any channel count, configurable subband geometry, mixed-block long-band count, and registered single-cycle handshakes. It sits between the stage handshake (`stage_ready`/`stage_done`) and the per-channel compute → windowing → overlap chains, which report completion of each subband via `band_done`.

## Interface
- `NUM_CH`, 2: number of independent channels.
- `SUBBANDS`, 32: subbands per granule.
- `LINES_PER_BAND`, 18: address stride per subband.
- `ADDR_W`, 10: base address width. `SUBBANDS*LINES_PER_BAND` must be ≤ 2^ADDR_W.
- `MIXED_BANDS`, 2: leading subbands forced to long blocks when a block is mixed.
- `TIMEOUT`, 1023: watchdog limit in cycles. Used only with `IMDCT_SCHED_WATCHDOG_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stage_ready` in 1: start-of-granule pulse.
- `block_type` in 2*NUM_CH: side-info block type; channel c uses bits [2c+1:2c].
- `window_switching_flag` in NUM_CH: per-channel side info.
- `mixed_block_flag` in NUM_CH: per-channel side info.
- `band_done` in NUM_CH: per-channel pulse meaning the current subband is fully written back.
- `start_subband` out NUM_CH: per-channel single-cycle pulse that launches one subband.
- `base_address` out ADDR_W*NUM_CH: per-channel first line of the current subband.
- `block_type_out` out 2*NUM_CH: per-channel effective block type for the current subband.
- `busy` out 1: high while any channel is not IDLE.
- `stage_done` out 1: single-cycle pulse when all channels have finished the granule.
- `timeout_err` out NUM_CH: sticky watchdog flag per channel. Tied to 0 without the macro.

## Operation
- Each channel runs its own FSM with states IDLE, START, WAIT and FIN, plus a band counter of width clog2(SUBBANDS).
- **IDLE:**
  - `stage_ready` is honoured only when every channel is IDLE.
  - On `stage_ready`, each channel latches `block_type`, `mixed_block_flag` and `window_switching_flag`, clears its band counter and `base_address`, and moves to START.
- **START:**
  - `start_subband[c]` is 1 for exactly this one cycle.
  - Move to WAIT.
- **WAIT:**
  - On `band_done[c]` when band == SUBBANDS-1: move to FIN.
  - On `band_done[c]` for any other band: increment band, add LINES_PER_BAND to `base_address`, move to START. The address is updated incrementally; no multiplier.
- **FIN:**
  - Hold until all channels are in FIN.
  - Then all channels return to IDLE together, and `stage_done` pulses high for one cycle.
- **Effective block type:** `block_type_out[c]` = 0 when the latched mixed AND window_switching flags are set and band < MIXED_BANDS. Otherwise it is the latched `block_type`. It is valid from START through WAIT.
- **Ignored inputs:**
  - `band_done` is ignored outside WAIT.
  - `stage_ready` is ignored while `busy`.
  - Side-info changes after latching have no effect until the next granule.
- **Reset:** from any state, reset returns all channels to IDLE. All outputs are 0: `start_subband`, `base_address`, `block_type_out`, `busy`, `stage_done`, `timeout_err`.

## Timing
- All outputs are registered.
- `stage_ready` high at cycle t → `start_subband` = all ones and `busy` = 1 at t+1.
- `band_done[c]` at cycle u (not the last band) → `base_address[c]` is updated and `start_subband[c]` pulses at u+1.
- Last `band_done` of the final channel at cycle u → FIN at u+1 → `stage_done` at u+2. `busy` drops at u+2.
- Simultaneous final `band_done` on several channels is a single join: exactly one `stage_done` pulse.
- A `band_done` arriving in the same cycle as `start_subband` is ignored, because that channel is still in START.
- Minimum per-subband period is 2 cycles, giving a minimum granule time of 2*SUBBANDS+2 cycles.
- Address wrap-around cannot occur within a granule: the last base is (SUBBANDS-1)*LINES_PER_BAND.

## Configuration
- **`IMDCT_SCHED_WATCHDOG_EN` defined:**
  - Each channel has a counter that is cleared on entry to WAIT and increments while in WAIT.
  - If it reaches TIMEOUT without a `band_done`, `timeout_err[c]` is set (sticky until `rst`).
  - The channel then advances exactly as if `band_done` had arrived, so the granule always completes.
- **`IMDCT_SCHED_WATCHDOG_EN` undefined:**
  - No counter logic is built.
  - `timeout_err` is constant 0.
  - A missing `band_done` stalls that channel indefinitely.

## Test plan
- Reset check: assert `rst` for 3 cycles → all outputs 0 and `busy` = 0. Then pulse `stage_ready`, with `band_done` returned 4 cycles after each start → `start_subband` pulses once at t+1.
- Long blocks on 2 channels (block_type 0, no mixed flag), `band_done` 3 cycles after each start → 32 starts per channel with bases 0, 18, …, 558; `block_type_out` = 0; exactly one `stage_done`, two cycles after the final `band_done`.
- Mixed short block on ch0 (block_type 2, mixed = 1, wsf = 1), ch1 pure short → ch0 `block_type_out` = 0 for bases 0 and 18, then 2; ch1 = 2 throughout.
- Skew between channels (ch1 `band_done` delayed 10 cycles relative to ch0) → ch0 waits in FIN; `stage_done` fires two cycles after ch1's last `band_done`. A `stage_ready` pulsed mid-granule is ignored, with no extra starts.
- Reset at band 7 followed by a new `stage_ready` → restart from base 0 with no stale pulses.
- With the macro, TIMEOUT = 15, ch1 never returns `band_done` for band 5 → `timeout_err` = 2'b10 after 15 WAIT cycles, band 6 starts, and the granule completes.
